// File: rtl/scr1_dmem_arb.sv
// Two-port data-memory arbiter: picks one requester per cycle, records each accepted
// transfer's owner in an in-order ID FIFO and routes bridge responses back to it.
// Define SCR1_DMEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority (port 0 first).
module scr1_dmem_arb #(
  parameter int SCR1_ARB_DEPTH = 4,
  parameter int SCR1_AHB_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // Port 0 (core LSU)
  input  logic                      req0,
  output logic                      req0_ack,
  input  logic                      cmd0,
  input  logic [1:0]                width0,
  input  logic [SCR1_AHB_WIDTH-1:0] addr0,
  input  logic [SCR1_AHB_WIDTH-1:0] wdata0,
  output logic [SCR1_AHB_WIDTH-1:0] rdata0,
  output logic [1:0]                resp0,
  // Port 1 (secondary requester)
  input  logic                      req1,
  output logic                      req1_ack,
  input  logic                      cmd1,
  input  logic [1:0]                width1,
  input  logic [SCR1_AHB_WIDTH-1:0] addr1,
  input  logic [SCR1_AHB_WIDTH-1:0] wdata1,
  output logic [SCR1_AHB_WIDTH-1:0] rdata1,
  output logic [1:0]                resp1,
  // Bridge side
  output logic                      mst_req,
  output logic                      mst_cmd,
  output logic [1:0]                mst_width,
  output logic [SCR1_AHB_WIDTH-1:0] mst_addr,
  output logic [SCR1_AHB_WIDTH-1:0] mst_wdata,
  input  logic                      mst_req_ack,
  input  logic [SCR1_AHB_WIDTH-1:0] mst_rdata,
  input  logic [1:0]                mst_resp,
  output logic                      arb_err
);

  localparam int CNT_W = $clog2(SCR1_ARB_DEPTH + 1);
  localparam int PTR_W = $clog2(SCR1_ARB_DEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(SCR1_ARB_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(SCR1_ARB_DEPTH - 1);
  localparam logic [1:0]       RESP_NOTRDY = 2'd0;

  logic             sel;
  logic             sel_q;
  logic             sel_req;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             id_q [SCR1_ARB_DEPTH];
  logic             arb_err_q, arb_err_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             resp_vld;
  logic             head;

`ifdef SCR1_DMEM_ARB_RR_EN
  logic last_q;

  // Port granted by the most recent transfer; resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (push) begin
      last_q <= sel;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = sel_q;
`ifdef SCR1_DMEM_ARB_RR_EN
    if (req0 && req1) begin
      sel = ~last_q;
    end else if (req0) begin
      sel = 1'b0;
    end else if (req1) begin
      sel = 1'b1;
    end
`else
    if (req0) begin
      sel = 1'b0;
    end else if (req1) begin
      sel = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Request forwarding
  // ---------------------------------------------------------------------------
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);

  assign sel_req   = sel ? req1 : req0;
  // Full blocks requests even when a pop lands in the same cycle: no mst_resp->ack path.
  assign mst_req   = sel_req & ~fifo_full;
  assign req0_ack  = mst_req & mst_req_ack & ~sel;
  assign req1_ack  = mst_req & mst_req_ack &  sel;

  assign mst_cmd   = sel ? cmd1   : cmd0;
  assign mst_width = sel ? width1 : width0;
  assign mst_addr  = sel ? addr1  : addr0;
  assign mst_wdata = sel ? wdata1 : wdata0;

  assign push = mst_req & mst_req_ack;

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  assign resp_vld = (mst_resp != RESP_NOTRDY);
  assign pop      = resp_vld & ~fifo_empty;
  assign head     = id_q[rd_ptr_q];

  assign resp0  = (pop && !head) ? mst_resp : RESP_NOTRDY;
  assign resp1  = (pop &&  head) ? mst_resp : RESP_NOTRDY;
  assign rdata0 = mst_rdata;
  assign rdata1 = mst_rdata;

  assign arb_err = arb_err_q;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    arb_err_d = arb_err_q | (resp_vld & fifo_empty);

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      arb_err_q <= 1'b0;
    end else begin
      sel_q     <= sel;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      arb_err_q <= arb_err_d;
    end
  end

  // NOTE: ID storage is not reset; an entry is only read while the count marks it valid.
  always_ff @(posedge clk) begin
    if (push) begin
      id_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_scr1_dmem_arb.sv
// Self-checking bench for scr1_dmem_arb: table vectors, directed corner sequences and
// randomized traffic checked against a queue-based model of the owner-tracking rules.
module tb_scr1_dmem_arb;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  localparam logic [1:0] NOTRDY = 2'd0;
  localparam logic [1:0] OK     = 2'd1;
  localparam logic [1:0] ER     = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, req0_ack, req1_ack;
  logic          cmd0, cmd1;
  logic [1:0]    width0, width1;
  logic [AW-1:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
  logic [1:0]    resp0, resp1;
  logic          mst_req, mst_cmd, mst_req_ack;
  logic [1:0]    mst_width, mst_resp;
  logic [AW-1:0] mst_addr, mst_wdata, mst_rdata;
  logic          arb_err;

  always #5 clk = ~clk;

  scr1_dmem_arb #(.SCR1_ARB_DEPTH(DEPTH), .SCR1_AHB_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req0_ack(req0_ack), .cmd0(cmd0), .width0(width0),
    .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .resp0(resp0),
    .req1(req1), .req1_ack(req1_ack), .cmd1(cmd1), .width1(width1),
    .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .resp1(resp1),
    .mst_req(mst_req), .mst_cmd(mst_cmd), .mst_width(mst_width),
    .mst_addr(mst_addr), .mst_wdata(mst_wdata), .mst_req_ack(mst_req_ack),
    .mst_rdata(mst_rdata), .mst_resp(mst_resp), .arb_err(arb_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owners of outstanding transfers in arrival order
  int unsigned m_ids[$];
  bit          m_err;
  bit          m_sel;
  bit          m_last;

  // Values sampled from the DUT in the most recent cycle
  logic          s_mst_req, s_ack0, s_ack1, s_err;
  logic [1:0]    s_resp0, s_resp1;
  logic [AW-1:0] s_rdata0;

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; mst_req_ack = 1'b0; mst_resp = NOTRDY;
    cmd0 = 1'b0; cmd1 = 1'b0; width0 = 2'd0; width1 = 2'd0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mst_rdata = '0;
    m_ids.delete();
    m_err  = 1'b0;
    m_sel  = 1'b0;
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance the model at the edge.
  task automatic cycle(input bit r0, input bit r1, input bit ack,
                       input logic [1:0] rsp, input logic [AW-1:0] rd);
    bit         g, full, exp_req, e0, e1;
    logic [1:0] er0, er1;
    req0 = r0; req1 = r1; mst_req_ack = ack; mst_resp = rsp; mst_rdata = rd;
    cmd0   = 1'($urandom_range(0, 1));  cmd1   = 1'($urandom_range(0, 1));
    width0 = 2'($urandom_range(0, 2));  width1 = 2'($urandom_range(0, 2));
    addr0  = $urandom; addr1  = $urandom;
    wdata0 = $urandom; wdata1 = $urandom;
    @(negedge clk);

    g = m_sel;
`ifdef SCR1_DMEM_ARB_RR_EN
    if (r0 && r1)  g = ~m_last;
    else if (r0)   g = 1'b0;
    else if (r1)   g = 1'b1;
`else
    if (r0)        g = 1'b0;
    else if (r1)   g = 1'b1;
`endif
    full    = (m_ids.size() == DEPTH);
    exp_req = (g ? r1 : r0) && !full;
    e0      = exp_req && ack && !g;
    e1      = exp_req && ack &&  g;
    er0     = NOTRDY;
    er1     = NOTRDY;
    if (rsp != NOTRDY && m_ids.size() > 0) begin
      if (m_ids[0] == 0) er0 = rsp;
      else               er1 = rsp;
    end

    check("mst_req",   mst_req,   exp_req);
    check("req0_ack",  req0_ack,  e0);
    check("req1_ack",  req1_ack,  e1);
    check("resp0",     resp0,     er0);
    check("resp1",     resp1,     er1);
    check("arb_err",   arb_err,   m_err);
    check("rdata0",    rdata0,    rd);
    check("rdata1",    rdata1,    rd);
    check("mst_addr",  mst_addr,  g ? addr1  : addr0);
    check("mst_wdata", mst_wdata, g ? wdata1 : wdata0);
    check("mst_cmd",   mst_cmd,   g ? cmd1   : cmd0);
    check("mst_width", mst_width, g ? width1 : width0);

    s_mst_req = mst_req; s_ack0 = req0_ack; s_ack1 = req1_ack; s_err = arb_err;
    s_resp0 = resp0; s_resp1 = resp1; s_rdata0 = rdata0;

    if (rsp != NOTRDY) begin
      if (m_ids.size() > 0) void'(m_ids.pop_front());
      else                  m_err = 1'b1;
    end
    if (exp_req && ack) begin
      m_ids.push_back(int'(g));
      m_last = g;
    end
    m_sel = g;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         r0, r1, ack;
    logic [1:0] rsp;
    bit         x_req, x_ack0, x_ack1;
    logic [1:0] x_resp0, x_resp1;
    bit         x_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit exp_ack0;

    tbl[0] = '{0, 0, 0, NOTRDY, 0, 0, 0, NOTRDY, NOTRDY, 0};
    tbl[1] = '{1, 0, 1, NOTRDY, 1, 1, 0, NOTRDY, NOTRDY, 0};
    tbl[2] = '{0, 1, 1, OK,     1, 0, 1, OK,     NOTRDY, 0};
    tbl[3] = '{0, 0, 0, ER,     0, 0, 0, NOTRDY, ER,     0};
    tbl[4] = '{0, 0, 0, OK,     0, 0, 0, NOTRDY, NOTRDY, 0};
    tbl[5] = '{0, 0, 0, NOTRDY, 0, 0, 0, NOTRDY, NOTRDY, 1};
    tbl[6] = '{0, 1, 0, NOTRDY, 1, 0, 0, NOTRDY, NOTRDY, 1};
    tbl[7] = '{0, 1, 1, OK,     1, 0, 1, NOTRDY, NOTRDY, 1};
    tbl[8] = '{0, 0, 0, OK,     0, 0, 0, NOTRDY, OK,     1};

    do_reset();

    // Reset state: no responses, mst_req follows req0
    cycle(1'b1, 1'b0, 1'b0, NOTRDY, '0);
    check("rst_mst_req", s_mst_req, 1'b1);
    check("rst_resp0",   s_resp0,   NOTRDY);
    check("rst_resp1",   s_resp1,   NOTRDY);
    check("rst_err",     s_err,     1'b0);

    // Table vectors, applied from a fresh reset
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].r0, tbl[i].r1, tbl[i].ack, tbl[i].rsp, $urandom);
      check($sformatf("tbl%0d_req",   i), s_mst_req, tbl[i].x_req);
      check($sformatf("tbl%0d_ack0",  i), s_ack0,    tbl[i].x_ack0);
      check($sformatf("tbl%0d_ack1",  i), s_ack1,    tbl[i].x_ack1);
      check($sformatf("tbl%0d_resp0", i), s_resp0,   tbl[i].x_resp0);
      check($sformatf("tbl%0d_resp1", i), s_resp1,   tbl[i].x_resp1);
      check($sformatf("tbl%0d_err",   i), s_err,     tbl[i].x_err);
    end

    // Single read on port 0, response two cycles later
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, NOTRDY, '0);
    check("rd_ack0", s_ack0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, NOTRDY, '0);
    cycle(1'b0, 1'b0, 1'b0, OK, 32'hDEAD_BEEF);
    check("rd_resp0", s_resp0,  OK);
    check("rd_resp1", s_resp1,  NOTRDY);
    check("rd_data0", s_rdata0, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b0, 1'b0, OK, '0);
    check("rd_empty_resp0", s_resp0, NOTRDY);
    cycle(1'b0, 1'b0, 1'b0, NOTRDY, '0);
    check("rd_empty_err", s_err, 1'b1);

    // Both ports request continuously with a response every cycle
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b1, 1'b1, (k == 0) ? NOTRDY : OK, $urandom);
`ifdef SCR1_DMEM_ARB_RR_EN
      exp_ack0 = (k % 2 == 0);
`else
      exp_ack0 = 1'b1;
`endif
      check($sformatf("both%0d_ack0", k), s_ack0, exp_ack0);
      check($sformatf("both%0d_ack1", k), s_ack1, !exp_ack0);
    end
    cycle(1'b0, 1'b1, 1'b1, OK, $urandom);
    check("both_drop_ack1", s_ack1, 1'b1);

    // Outstanding limit: DEPTH acks, next blocked even with a same-cycle pop
    do_reset();
    for (int k = 0; k <= DEPTH; k++) begin
      cycle(1'b1, 1'b0, 1'b1, NOTRDY, '0);
      check($sformatf("full%0d_ack0", k), s_ack0,    k < DEPTH);
      check($sformatf("full%0d_req",  k), s_mst_req, k < DEPTH);
    end
    cycle(1'b1, 1'b0, 1'b1, OK, $urandom);
    check("full_pop_req",   s_mst_req, 1'b0);
    check("full_pop_resp0", s_resp0,   OK);
    cycle(1'b1, 1'b0, 1'b1, NOTRDY, '0);
    check("full_unblock_ack0", s_ack0, 1'b1);

    // Interleaved owners 1,0,1 with OK/ER/OK responses, then a spurious one
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, NOTRDY, '0);
    cycle(1'b1, 1'b0, 1'b1, NOTRDY, '0);
    cycle(1'b0, 1'b1, 1'b1, NOTRDY, '0);
    cycle(1'b0, 1'b0, 1'b0, OK, $urandom);
    check("il_a_resp1", s_resp1, OK);
    check("il_a_resp0", s_resp0, NOTRDY);
    cycle(1'b0, 1'b0, 1'b0, ER, $urandom);
    check("il_b_resp0", s_resp0, ER);
    check("il_b_resp1", s_resp1, NOTRDY);
    cycle(1'b0, 1'b0, 1'b0, OK, $urandom);
    check("il_c_resp1", s_resp1, OK);
    cycle(1'b0, 1'b0, 1'b0, OK, $urandom);
    check("il_extra_resp0", s_resp0, NOTRDY);
    check("il_extra_resp1", s_resp1, NOTRDY);
    cycle(1'b0, 1'b0, 1'b0, NOTRDY, '0);
    check("il_err_set", s_err, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, NOTRDY, '0);
    check("il_err_sticky", s_err, 1'b1);
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, NOTRDY, '0);
    check("il_err_cleared", s_err, 1'b0);

    // Reset with three transfers outstanding; a late response follows release
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b1, NOTRDY, '0);
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, OK, $urandom);
    check("mid_ack0",  s_ack0,  1'b1);
    check("mid_resp0", s_resp0, NOTRDY);
    check("mid_resp1", s_resp1, NOTRDY);
    cycle(1'b0, 1'b0, 1'b0, NOTRDY, '0);
    check("mid_late_err", s_err, 1'b1);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bit         r0, r1, ak;
      logic [1:0] rsp;
      r0  = ($urandom_range(0, 99) < 60);
      r1  = ($urandom_range(0, 99) < 60);
      ak  = ($urandom_range(0, 3) != 0);
      rsp = NOTRDY;
      if (m_ids.size() > 0 && $urandom_range(0, 2) != 0)
        rsp = ($urandom_range(0, 4) == 0) ? ER : OK;
      else if ($urandom_range(0, 59) == 0)
        rsp = OK;
      cycle(r0, r1, ak, rsp, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
